// File: rtl/window_sequencer.sv
// Window sequencer: runs num_windows SEND/INCREASE/PAUSE/LISTEN windows, then FINISH.
// Optional calibration outputs are compiled in with WINSEQ_CALIB_EN.
module window_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window_send_time,
    input  logic [CNT_W-1:0] window_increase_time,
    input  logic [CNT_W-1:0] window_pause_time,
    input  logic [CNT_W-1:0] window_listen_time,
    input  logic [WIN_W-1:0] num_windows,
    input  logic             lfd_disable_before,
    input  logic             lfd_enable_after,
    input  logic             calibration_mode,
    input  logic             pause_action_required,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [WIN_W-1:0] window_idx,
    output logic             send_en,
    output logic             increase_en,
    output logic             listen_en,
    output logic             lfd_disable,
    output logic             lfd_enable,
    output logic             pause_act,
    output logic             window_done,
    output logic             done,
    output logic             calib_active
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEND   = 3'd1;
    localparam logic [2:0] S_INC    = 3'd2;
    localparam logic [2:0] S_PAUSE  = 3'd3;
    localparam logic [2:0] S_LISTEN = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] t_send_q, t_inc_q, t_pause_q, t_listen_q;
    logic [CNT_W-1:0] t_send_d, t_inc_d, t_pause_d, t_listen_d;
    logic [WIN_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] phase_last;
    logic             phase_end;
    logic [WIN_W:0]   idx_inc;
    logic             busy_d, send_en_d, increase_en_d, listen_en_d, window_done_d, done_d;

    // Last counter value of a phase; a zero length still occupies one cycle.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        t_send_d   = t_send_q;
        t_inc_d    = t_inc_q;
        t_pause_d  = t_pause_q;
        t_listen_d = t_listen_q;
        num_d      = num_q;
        idx_inc    = {1'b0, idx_q} + (WIN_W+1)'(1);
        case (state_q)
            S_SEND:   phase_last = last_of(t_send_q);
            S_INC:    phase_last = last_of(t_inc_q);
            S_PAUSE:  phase_last = last_of(t_pause_q);
            S_LISTEN: phase_last = last_of(t_listen_q);
            default:  phase_last = '0;
        endcase
        phase_end = (cnt_q >= phase_last);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) begin
                    t_send_d   = window_send_time;
                    t_inc_d    = window_increase_time;
                    t_pause_d  = window_pause_time;
                    t_listen_d = window_listen_time;
                    num_d      = num_windows;
                    state_d    = (num_windows == '0) ? S_FINISH : S_SEND;
                end
            end
            S_SEND:   if (phase_end) state_d = S_INC;
            S_INC:    if (phase_end) state_d = S_PAUSE;
            S_PAUSE:  if (phase_end) state_d = S_LISTEN;
            S_LISTEN: begin
                if (phase_end) begin
                    if (idx_inc < {1'b0, num_q}) begin
                        state_d = S_SEND;
                        idx_d   = idx_inc[WIN_W-1:0];
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_q == S_SEND || state_q == S_INC || state_q == S_PAUSE || state_q == S_LISTEN)
            cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);

        // Abort wins over any phase completion in the same cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
        if (state_d == S_IDLE) idx_d = '0;

        busy_d        = (state_d != S_IDLE);
        send_en_d     = (state_d == S_SEND);
        increase_en_d = (state_d == S_INC);
        listen_en_d   = (state_d == S_LISTEN);
        window_done_d = (state_d == S_LISTEN) && (cnt_d == last_of(t_listen_q));
        done_d        = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            t_send_q    <= '0;
            t_inc_q     <= '0;
            t_pause_q   <= '0;
            t_listen_q  <= '0;
            num_q       <= '0;
            busy        <= 1'b0;
            send_en     <= 1'b0;
            increase_en <= 1'b0;
            listen_en   <= 1'b0;
            window_done <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            t_send_q    <= t_send_d;
            t_inc_q     <= t_inc_d;
            t_pause_q   <= t_pause_d;
            t_listen_q  <= t_listen_d;
            num_q       <= num_d;
            busy        <= busy_d;
            send_en     <= send_en_d;
            increase_en <= increase_en_d;
            listen_en   <= listen_en_d;
            window_done <= window_done_d;
            done        <= done_d;
        end
    end

    assign phase      = state_q;
    assign window_idx = idx_q;

`ifdef WINSEQ_CALIB_EN
    // flags: {calibration_mode, lfd_disable_before, lfd_enable_after, pause_action_required}
    logic [3:0] flags_q, flags_d;
    logic       lfd_disable_d, lfd_enable_d, pause_act_d, calib_active_d;

    always_comb begin
        flags_d = flags_q;
        if (state_q == S_IDLE && start)
            flags_d = {calibration_mode, lfd_disable_before, lfd_enable_after, pause_action_required};
        lfd_disable_d  = flags_d[2] && (state_d == S_SEND || state_d == S_INC);
        lfd_enable_d   = flags_d[1] && window_done_d;
        pause_act_d    = flags_d[0] && (state_d == S_PAUSE) && (cnt_d == '0);
        calib_active_d = flags_d[3] && busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= '0;
            lfd_disable  <= 1'b0;
            lfd_enable   <= 1'b0;
            pause_act    <= 1'b0;
            calib_active <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            lfd_disable  <= lfd_disable_d;
            lfd_enable   <= lfd_enable_d;
            pause_act    <= pause_act_d;
            calib_active <= calib_active_d;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{lfd_disable_before, lfd_enable_after, calibration_mode, pause_action_required};
    assign lfd_disable  = 1'b0;
    assign lfd_enable   = 1'b0;
    assign pause_act    = 1'b0;
    assign calib_active = 1'b0;
`endif

endmodule

// File: tb/tb_window_sequencer.sv
// Bench for window_sequencer: vector table, hand-written abort/reset/relaunch runs,
// and random traffic against a schedule-queue reference model.
module tb_window_sequencer;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned WIN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, start, abort;
    logic [CNT_W-1:0] t_send, t_inc, t_pause, t_listen;
    logic [WIN_W-1:0] num;
    logic             f_dis, f_ena, f_cal, f_pa;
    logic             busy, send_en, increase_en, listen_en, lfd_disable, lfd_enable;
    logic             pause_act, window_done, done, calib_active;
    logic [2:0]       phase;
    logic [WIN_W-1:0] window_idx;

    window_sequencer #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .window_send_time(t_send), .window_increase_time(t_inc),
        .window_pause_time(t_pause), .window_listen_time(t_listen),
        .num_windows(num), .lfd_disable_before(f_dis), .lfd_enable_after(f_ena),
        .calibration_mode(f_cal), .pause_action_required(f_pa),
        .busy(busy), .phase(phase), .window_idx(window_idx),
        .send_en(send_en), .increase_en(increase_en), .listen_en(listen_en),
        .lfd_disable(lfd_disable), .lfd_enable(lfd_enable), .pause_act(pause_act),
        .window_done(window_done), .done(done), .calib_active(calib_active)
    );

    always #10 clk = ~clk;

    typedef struct {
        int ph;
        int idx;
        bit first;
        bit last;
    } rec_t;

    typedef struct {
        int s, i, p, l, n;
        int done_cyc;
        int wd_count;
        int first_wd;
    } vec_t;

    rec_t q[$];
    rec_t cur;
    bit   m_dis, m_ena, m_cal, m_pa;
    int   checks = 0, failures = 0;
    int   cyc, done_cyc, wd_count, first_wd;

    function automatic rec_t idle_rec();
        rec_t r;
        r.ph = 0; r.idx = 0; r.first = 1'b0; r.last = 1'b0;
        return r;
    endfunction

    // Expand the latched profile into one record per expected busy cycle.
    task automatic build_schedule();
        int times[4];
        rec_t r;
        times[0] = int'(t_send); times[1] = int'(t_inc);
        times[2] = int'(t_pause); times[3] = int'(t_listen);
        m_dis = f_dis; m_ena = f_ena; m_cal = f_cal; m_pa = f_pa;
        q.delete();
        for (int w = 0; w < int'(num); w++) begin
            for (int p = 0; p < 4; p++) begin
                int t;
                t = (times[p] == 0) ? 1 : times[p];
                for (int k = 0; k < t; k++) begin
                    r.ph = p + 1; r.idx = w; r.first = (k == 0); r.last = (k == t - 1);
                    q.push_back(r);
                end
            end
        end
        r.ph = 5; r.idx = (num == 0) ? 0 : int'(num) - 1; r.first = 1'b1; r.last = 1'b1;
        q.push_back(r);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            q.delete();
            cur = idle_rec();
        end else if (cur.ph != 0) begin
            if (abort) begin
                q.delete();
                cur = idle_rec();
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = idle_rec();
            end
        end else if (start) begin
            build_schedule();
            cur = q.pop_front();
        end
    endtask

    function automatic logic [20:0] exp_vec();
        logic b, wd, dis, ena, pa, cal;
        b   = (cur.ph != 0);
        wd  = (cur.ph == 4) && cur.last;
`ifdef WINSEQ_CALIB_EN
        dis = m_dis && (cur.ph == 1 || cur.ph == 2);
        ena = m_ena && wd;
        pa  = m_pa && (cur.ph == 3) && cur.first;
        cal = m_cal && b;
`else
        dis = 1'b0; ena = 1'b0; pa = 1'b0; cal = 1'b0;
`endif
        return {b, 3'(cur.ph), 8'(cur.idx), cur.ph == 1, cur.ph == 2, cur.ph == 4,
                wd, cur.ph == 5, dis, ena, pa, cal};
    endfunction

    function automatic logic [20:0] act_vec();
        return {busy, phase, window_idx, send_en, increase_en, listen_en,
                window_done, done, lfd_disable, lfd_enable, pause_act, calib_active};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("outputs", 32'(act_vec()), 32'(exp_vec()));
        if (window_done) begin
            wd_count++;
            if (first_wd < 0) first_wd = cyc;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic set_profile(input int s, input int i, input int p, input int l, input int n);
        t_send = CNT_W'(s); t_inc = CNT_W'(i); t_pause = CNT_W'(p);
        t_listen = CNT_W'(l); num = WIN_W'(n);
    endtask

    task automatic clear_events();
        cyc = 0; done_cyc = -1; wd_count = 0; first_wd = -1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3, 4, 2, 5, 2, 29, 2, 14};
        vecs[1] = '{3, 4, 2, 5, 0, 1, 0, -1};
        vecs[2] = '{0, 0, 0, 0, 3, 13, 3, 4};
        vecs[3] = '{1, 1, 1, 1, 1, 5, 1, 4};
        vecs[4] = '{0, 2, 0, 3, 2, 15, 2, 7};
        vecs[5] = '{5, 1, 3, 2, 1, 12, 1, 11};

        cur = idle_rec();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        f_dis = 1'b1; f_ena = 1'b1; f_cal = 1'b1; f_pa = 1'b1;
        set_profile(3, 4, 2, 5, 2);
        clear_events();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Table: one start pulse per profile, record event timing.
        foreach (vecs[v]) begin
            set_profile(vecs[v].s, vecs[v].i, vecs[v].p, vecs[v].l, vecs[v].n);
            clear_events();
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (vecs[v].done_cyc + 3) tick();
            check("done_cycle", 32'(done_cyc), 32'(vecs[v].done_cyc));
            check("window_done_count", 32'(wd_count), 32'(vecs[v].wd_count));
            check("first_window_done", 32'(first_wd), 32'(vecs[v].first_wd));
        end

        // Abort during INCREASE: idle next cycle, no done afterwards.
        set_profile(3, 4, 2, 5, 2);
        clear_events();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (30) tick();
        check("abort_no_done", 32'(done_cyc), 32'hffff_ffff);

        // Asynchronous reset at cycle 20 of a fresh run.
        clear_events();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'(act_vec()), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("reset_no_done", 32'(done_cyc), 32'hffff_ffff);

        // start held high; profile changes mid-run only affect the relaunch.
        set_profile(3, 4, 2, 5, 2);
        clear_events();
        start = 1'b1;
        tick();
        repeat (4) tick();
        set_profile(1, 1, 1, 1, 1);
        repeat (24) tick();
        check("held_done_cycle", 32'(done_cyc), 32'd29);
        tick();
        check("held_idle_at_30", 32'(phase), 32'd0);
        done_cyc = -1;
        tick();
        check("relaunch_send_at_31", 32'(phase), 32'd1);
        start = 1'b0;
        repeat (6) tick();
        check("relaunch_done_cycle", 32'(done_cyc), 32'd35);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            f_dis = 1'($urandom); f_ena = 1'($urandom);
            f_cal = 1'($urandom); f_pa = 1'($urandom);
            set_profile($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, phase-counter/time width.
REQ-002 SHALL have parameter WIN_W, default 8, window-count/index width.
REQ-003 SHALL have ports clk  in  1  system clock (50 MHz nominal); rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports start  in  1  begin sequence (level, sampled in IDLE); abort  in  1  stop sequence.
REQ-005 SHALL have ports window_send_time, window_increase_time, window_pause_time, window_listen_time  in  CNT_W each  phase length in clk cycles.
REQ-006 SHALL have ports num_windows  in  WIN_W  window count; lfd_disable_before, lfd_enable_after, calibration_mode, pause_action_required  in  1 each  profile flags.
REQ-007 SHALL have ports busy  out  1; phase  out  3  (0 IDLE, 1 SEND, 2 INCREASE, 3 PAUSE, 4 LISTEN, 5 FINISH); window_idx  out  WIN_W  current window.
REQ-008 SHALL have ports send_en, increase_en, listen_en  out  1 each  phase enables; lfd_disable  out  1  level; lfd_enable  out  1  pulse; pause_act  out  1  pulse; window_done  out  1  pulse; done  out  1  pulse; calib_active  out  1  level.

Function
REQ-009 SHALL implement FSM IDLE -> SEND -> INCREASE -> PAUSE -> LISTEN -> (SEND of next window | FINISH) -> IDLE.
REQ-010 SHALL snapshot all profile inputs on the edge where start is sampled high in IDLE; input changes while busy are ignored.
REQ-011 SHALL enter SEND with window_idx=0 on the cycle after start is sampled (1-cycle latency).
REQ-012 SHALL hold each phase exactly T cycles (T = latched time); T=0 SHALL be treated as 1 cycle.
REQ-013 SHALL assert send_en/increase_en/listen_en only while phase = SEND/INCREASE/LISTEN respectively; no enable in PAUSE.
REQ-014 SHALL pulse window_done for 1 cycle on the last LISTEN cycle of every window.
REQ-015 SHALL, after LISTEN of window i, go to SEND with window_idx=i+1 if i+1 < num_windows, else FINISH.
REQ-016 SHALL stay in FINISH 1 cycle with done=1, busy=1, then IDLE with busy=0.
REQ-017 SHALL, if latched num_windows=0, go IDLE -> FINISH directly (done pulse on cycle after start, no windows).
REQ-018 SHALL ignore start while busy; start held high after FINISH SHALL relaunch from IDLE on the next edge.
REQ-019 SHALL, on abort high in any non-IDLE state, return to IDLE next cycle with all outputs at reset values and no done/window_done; abort has priority over phase completion.
REQ-020 SHALL keep the phase counter CNT_W wide, counting 0..T-1, with no wrap for T up to 2^CNT_W-1.
REQ-021 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-022 SHALL on rst_n low force IDLE, phase=0, window_idx=0, counter=0 and all outputs 0, asynchronously.
REQ-023 SHALL, with reset asserted mid-sequence, emit no done and resume only on a new start.

Configuration
REQ-024 SHALL compile calibration support when macro WINSEQ_CALIB_EN is defined: calib_active = latched calibration_mode while busy; lfd_disable=1 from SEND entry through end of INCREASE if lfd_disable_before; pause_act 1-cycle pulse on first PAUSE cycle if pause_action_required; lfd_enable 1-cycle pulse coincident with window_done if lfd_enable_after.
REQ-025 SHALL, without WINSEQ_CALIB_EN, tie calib_active, lfd_disable, pause_act, lfd_enable to 0 and ignore the four flags; sequencing unchanged.

Verification
REQ-026 send=3, inc=4, pause=2, listen=5, num=2, start at edge 0 -> SEND cycles 1-3, INCREASE 4-7, PAUSE 8-9, LISTEN 10-14, window_done 14 and 28, done 29, busy=0 at 30.
REQ-027 num_windows=0, start at edge 0 -> phase=FINISH, done=1 at cycle 1; no enables; IDLE at cycle 2.
REQ-028 all times 0, num=3 -> each window 4 cycles; done at cycle 13.
REQ-029 REQ-026 profile, abort at cycle 6 -> IDLE at cycle 7, no done; rst_n low at cycle 20 of a new run -> outputs 0 immediately.
REQ-030 WINSEQ_CALIB_EN defined, all flags 1, REQ-026 profile -> lfd_disable 1-7 and 15-21, pause_act at 8 and 22, lfd_enable at 14 and 28; undefined -> all four 0.
REQ-031 profile inputs changed at cycle 5 of a run and start held high throughout -> timing matches REQ-026; second run starts at cycle 31 with new values.
